// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle controller: opcode constants, FSM
// state encoding, mux-select encodings (also used by imm_gen), the packed
// control-output bundle and opcode classification helpers.
package mc_control_pkg;

    // Base-ISA major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    // Immediate format select (shared with imm_gen)
    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_S  = 2'b01;
    localparam logic [1:0] IMM_B  = 2'b10;
    localparam logic [1:0] IMM_UJ = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    // ALU operand A select
    localparam logic [1:0] ALUA_RS1  = 2'b00;
    localparam logic [1:0] ALUA_PC   = 2'b01;
    localparam logic [1:0] ALUA_ZERO = 2'b10;

    // ALU operand B select
    localparam logic ALUB_RS2 = 1'b0;
    localparam logic ALUB_IMM = 1'b1;

    // Write-back source select
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // Control outputs driven by the FSM (imm_sel is decoded separately)
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       halted;
        logic       fault;
    } ctrl_t;

    // Immediate format implied by an opcode
    function automatic logic [1:0] imm_sel_of(input logic [6:0] opc);
        logic [1:0] sel;
        case (opc)
            OPC_STORE:                    sel = IMM_S;
            OPC_BRANCH:                   sel = IMM_B;
            OPC_LUI, OPC_AUIPC, OPC_JAL:  sel = IMM_UJ;
            default:                      sel = IMM_I;
        endcase
        return sel;
    endfunction

    // Opcodes the controller can execute (SYSTEM is handled as halt)
    function automatic logic is_legal(input logic [6:0] opc);
        logic ok;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE: ok = 1'b1;
            default:                                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_control_timeout.sv
// mc_timeout: saturating memory-wait counter.
//   clk, rst     clock, async active-high reset
//   clear        zero the counter (wins over enable)
//   enable       count one waiting cycle
//   expired_c    counter has reached LIMIT (combinational from the flop)
module mc_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then increment, holding at LIMIT
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT_V)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q == LIMIT_V);

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I-style control FSM.
//   clk, rst      clock, async active-high reset
//   opcode        instr[6:0] from the instruction register
//   br_taken      branch compare result, sampled in EXEC
//   mem_ready     memory completes the current request this cycle
//   mem_req/mem_we/mem_addr_sel   memory request controls
//   ir_we, pc_we, pc_sel          instruction register / PC update
//   imm_sel                       immediate format (decoded from opcode in every state)
//   alu_a_sel, alu_b_sel          ALU operand selects
//   rf_we, wb_sel                 register write-back
//   halted, fault                 absorbing HALT / FAULT indication
// Outputs are decoded from the current state and inputs in the same cycle so
// that ir_we / pc_we line up with the mem_ready handshake.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [1:0] imm_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       fault
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   to_clear;
    logic   to_enable;
    logic   to_expired;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        ctrl    = '0;

        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_we = 1'b1;
                    state_d    = ST_DECODE;
                end else if (to_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_DECODE: begin
                if (opcode == OPC_SYSTEM) begin
                    state_d = ST_HALT;
                end else if (is_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FAULT;
                end
            end

            ST_EXEC: begin
                case (opcode)
                    OPC_LUI:   ctrl.alu_a_sel = ALUA_ZERO;
                    OPC_AUIPC: ctrl.alu_a_sel = ALUA_PC;
                    default:   ctrl.alu_a_sel = ALUA_RS1;
                endcase
                ctrl.alu_b_sel = ((opcode == OPC_OP) || (opcode == OPC_BRANCH))
                               ? ALUB_RS2 : ALUB_IMM;

                case (opcode)
                    OPC_LOAD, OPC_STORE: begin
                        state_d = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                        state_d     = ST_FETCH;
                    end
                    OPC_FENCE: begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = PC_PLUS4;
                        state_d     = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_WB;
                    end
                endcase
            end

            ST_MEM: begin
                ctrl.mem_req      = 1'b1;
                ctrl.mem_addr_sel = 1'b1;
                ctrl.mem_we       = (opcode == OPC_STORE);
                if (mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        // Stores have no write-back; retire the PC here
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = PC_PLUS4;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (to_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_WB: begin
                ctrl.rf_we = 1'b1;
                ctrl.pc_we = 1'b1;
                case (opcode)
                    OPC_LOAD:           ctrl.wb_sel = WB_LOAD;
                    OPC_JAL, OPC_JALR:  ctrl.wb_sel = WB_PC4;
                    default:            ctrl.wb_sel = WB_ALU;
                endcase
                case (opcode)
                    OPC_JAL:  ctrl.pc_sel = PC_IMM;
                    OPC_JALR: ctrl.pc_sel = PC_ALU;
                    default:  ctrl.pc_sel = PC_PLUS4;
                endcase
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                ctrl.halted = 1'b1;
            end

            ST_FAULT: begin
                ctrl.fault = 1'b1;
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase

        // Reset silences every control output immediately
        if (rst) begin
            ctrl = '0;
        end
    end

    // Wait counter restarts whenever a memory-request state is entered
    assign to_clear  = (state_d != state_q) &&
                       ((state_d == ST_FETCH) || (state_d == ST_MEM));
    assign to_enable = ctrl.mem_req && !mem_ready;

    mc_timeout #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear     (to_clear),
        .enable    (to_enable),
        .expired_c (to_expired)
    );

    assign mem_req      = ctrl.mem_req;
    assign mem_we       = ctrl.mem_we;
    assign mem_addr_sel = ctrl.mem_addr_sel;
    assign ir_we        = ctrl.ir_we;
    assign pc_we        = ctrl.pc_we;
    assign pc_sel       = ctrl.pc_sel;
    assign imm_sel      = imm_sel_of(opcode);
    assign alu_a_sel    = ctrl.alu_a_sel;
    assign alu_b_sel    = ctrl.alu_b_sel;
    assign rf_we        = ctrl.rf_we;
    assign wb_sel       = ctrl.wb_sel;
    assign halted       = ctrl.halted;
    assign fault        = ctrl.fault;

endmodule
